// File: rtl/hidden_wires_pkg.sv
// Shared types for the packet arbiter: beat layout, arbiter state, one-hot decode.
// Purely declarative; no timing or backpressure of its own.
package hidden_wires_pkg;

  localparam int BEAT_DW = 32;

  typedef struct packed {
    logic [BEAT_DW-1:0] data;
    logic               startofpacket;
    logic               endofpacket;
  } beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  // Returns the index of the set bit; a zero vector decodes to 0.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_picker.sv
// Round-robin picker: request vector plus last winner index gives a one-hot winner.
// Zero latency (combinational); no backpressure, a zero request vector yields zero.
module rr_picker #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Search starts one past the previous winner and wraps, so the previous winner is visited last.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = IDX_W'((int'(last_grant_i) + k) % NUM_PORTS);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin mux of NUM_PORTS streams onto one; 1 cycle to grant, 0 in-packet.
// out_ready is forwarded to the granted port only; others see in_ready=0 until their grant.
module packet_arbiter
  import hidden_wires_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_startofpacket,
  input  logic [NUM_PORTS-1:0]            in_endofpacket,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_startofpacket,
  output logic                            out_endofpacket,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            sop_error
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic                 first_beat_q, first_beat_d;
  logic                 sop_error_q, sop_error_d;
  logic [NUM_PORTS-1:0] pick;
  logic [IDX_W-1:0]     g_idx;
  logic                 accept;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req_i        (in_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (pick)
  );

  assign g_idx = IDX_W'(onehot_to_idx(16'(grant_q)));

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    first_beat_d      = first_beat_q;
    sop_error_d       = 1'b0;
    in_ready          = '0;
    out_valid         = 1'b0;
    out_data          = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    accept            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d      = pick;
          first_beat_d = 1'b1;
          state_d      = PASS;
        end
      end
      PASS: begin
        out_valid         = in_valid[g_idx];
        out_data          = in_data[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
        out_startofpacket = in_startofpacket[g_idx];
        out_endofpacket   = in_endofpacket[g_idx];
        in_ready[g_idx]   = out_ready;
        accept            = out_valid && out_ready;
        if (accept) begin
          first_beat_d = 1'b0;
          // A second SOP inside the same grant is flagged but still forwarded.
          sop_error_d  = out_startofpacket && !first_beat_q;
          if (out_endofpacket) begin
            state_d      = IDLE;
            last_grant_d = g_idx;
            grant_d      = '0;
            first_beat_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      first_beat_q <= 1'b1;
      sop_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_beat_q <= first_beat_d;
      sop_error_q  <= sop_error_d;
    end
  end

  assign grant     = grant_q;
  assign sop_error = sop_error_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter: reset, single packet, round-robin, stall, single-beat, SOP error, mid-packet reset.
module tb_packet_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_startofpacket;
  logic [3:0]   in_endofpacket;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_startofpacket;
  logic         out_endofpacket;
  logic [3:0]   grant;
  logic         sop_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packet_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .grant             (grant),
    .sop_error         (sop_error)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input logic v, input logic [31:0] d, input logic s, input logic e);
    in_valid[p]          = v;
    in_data[p*32 +: 32]  = d;
    in_startofpacket[p]  = s;
    in_endofpacket[p]    = e;
  endtask

  task automatic clear_inputs();
    in_valid         = '0;
    in_data          = '0;
    in_startofpacket = '0;
    in_endofpacket   = '0;
    out_ready        = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    drive_port(0, 1'b1, 32'h1111_0000, 1'b1, 1'b0);
    cyc();
    cyc();
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_checks++; if (sop_error !== 1'b0) begin n_fail++; $display("FAIL reset_sop_error: got %b want 0", sop_error); end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_packet();
    do_reset();
    drive_port(0, 1'b1, 32'hA0, 1'b1, 1'b0);
    #1;
    n_checks++; if (grant !== 4'b0000 || in_ready !== 4'b0000) begin n_fail++; $display("FAIL sp_idle: grant %b in_ready %b want 0000/0000", grant, in_ready); end
    cyc(); #1;
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL sp_grant: got %b want 0001", grant); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0 || out_startofpacket !== 1'b1 || out_endofpacket !== 1'b0) begin n_fail++; $display("FAIL sp_beat0: v%b d%h s%b e%b want v1 dA0 s1 e0", out_valid, out_data, out_startofpacket, out_endofpacket); end
    n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL sp_in_ready: got %b want 0001", in_ready); end
    cyc(); drive_port(0, 1'b1, 32'hA1, 1'b0, 1'b0); #1;
    n_checks++; if (out_data !== 32'hA1 || out_startofpacket !== 1'b0) begin n_fail++; $display("FAIL sp_beat1: d%h s%b want A1 s0", out_data, out_startofpacket); end
    cyc(); drive_port(0, 1'b1, 32'hA2, 1'b0, 1'b1); #1;
    n_checks++; if (out_data !== 32'hA2 || out_endofpacket !== 1'b1 || grant !== 4'b0001) begin n_fail++; $display("FAIL sp_beat2: d%h e%b g%b want A2 e1 g0001", out_data, out_endofpacket, grant); end
    cyc(); drive_port(0, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    n_checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin n_fail++; $display("FAIL sp_release: g%b v%b want 0000 v0", grant, out_valid); end
  endtask

  task automatic test_round_robin();
    int ep;
    do_reset();
    for (int p = 0; p < 4; p++) drive_port(p, 1'b1, 32'hC000_0000 | (p << 4), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ep = k % 4;
      #1;
      n_checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble%0d: g%b v%b want 0000 v0", k, grant, out_valid); end
      cyc(); #1;
      n_checks++; if (grant !== (4'b0001 << ep) || out_data !== (32'hC000_0000 | (ep << 4)) || out_startofpacket !== 1'b1) begin n_fail++; $display("FAIL rr_pkt%0d_b0: g%b d%h want g%b d%h", k, grant, out_data, 4'b0001 << ep, 32'hC000_0000 | (ep << 4)); end
      cyc(); drive_port(ep, 1'b1, 32'hC000_0001 | (ep << 4), 1'b0, 1'b1); #1;
      n_checks++; if (grant !== (4'b0001 << ep) || out_data !== (32'hC000_0001 | (ep << 4)) || out_endofpacket !== 1'b1) begin n_fail++; $display("FAIL rr_pkt%0d_b1: g%b d%h want g%b d%h", k, grant, out_data, 4'b0001 << ep, 32'hC000_0001 | (ep << 4)); end
      cyc(); drive_port(ep, 1'b1, 32'hC000_0000 | (ep << 4), 1'b1, 1'b0);
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    drive_port(2, 1'b1, 32'hD0, 1'b1, 1'b0);
    cyc();
    drive_port(0, 1'b1, 32'hE0, 1'b1, 1'b1);
    drive_port(3, 1'b1, 32'hF0, 1'b1, 1'b1);
    out_ready = 1'b1; #1;
    n_checks++; if (grant !== 4'b0100 || in_ready !== 4'b0100 || out_data !== 32'hD0) begin n_fail++; $display("FAIL st_start: g%b r%b d%h want 0100 0100 D0", grant, in_ready, out_data); end
    cyc(); drive_port(2, 1'b1, 32'hD1, 1'b0, 1'b0); out_ready = 1'b0; #1;
    n_checks++; if (in_ready !== 4'b0000 || out_data !== 32'hD1) begin n_fail++; $display("FAIL st_stall1: r%b d%h want 0000 D1", in_ready, out_data); end
    cyc(); #1;
    n_checks++; if (in_ready !== 4'b0000 || out_data !== 32'hD1 || grant !== 4'b0100) begin n_fail++; $display("FAIL st_stall2: r%b d%h g%b want 0000 D1 0100", in_ready, out_data, grant); end
    cyc(); out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 4'b0100 || out_data !== 32'hD1) begin n_fail++; $display("FAIL st_resume: r%b d%h want 0100 D1", in_ready, out_data); end
    cyc(); drive_port(2, 1'b1, 32'hD2, 1'b0, 1'b1); #1;
    n_checks++; if (out_data !== 32'hD2 || out_endofpacket !== 1'b1 || in_ready !== 4'b0100) begin n_fail++; $display("FAIL st_eop: d%h e%b r%b want D2 1 0100", out_data, out_endofpacket, in_ready); end
    cyc(); drive_port(2, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL st_release: g%b want 0000", grant); end
    cyc(); #1;
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL st_next_port3: g%b want 1000", grant); end
    clear_inputs();
  endtask

  task automatic test_single_beat();
    logic [3:0] exp_g;
    do_reset();
    drive_port(1, 1'b1, 32'h51, 1'b1, 1'b1);
    drive_port(3, 1'b1, 32'h53, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      cyc(); #1;
      n_checks++; if (grant !== exp_g || out_startofpacket !== 1'b1 || out_endofpacket !== 1'b1) begin n_fail++; $display("FAIL sb_grant%0d: g%b s%b e%b want %b s1 e1", k, grant, out_startofpacket, out_endofpacket, exp_g); end
      cyc(); #1;
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL sb_idle%0d: g%b want 0000", k, grant); end
    end
    clear_inputs();
  endtask

  task automatic test_sop_error();
    do_reset();
    drive_port(1, 1'b1, 32'hE0, 1'b1, 1'b0);
    cyc(); #1;
    n_checks++; if (grant !== 4'b0010 || sop_error !== 1'b0) begin n_fail++; $display("FAIL se_grant: g%b err%b want 0010 0", grant, sop_error); end
    cyc(); drive_port(1, 1'b1, 32'hE1, 1'b1, 1'b0); #1;
    n_checks++; if (sop_error !== 1'b0 || out_data !== 32'hE1 || out_startofpacket !== 1'b1) begin n_fail++; $display("FAIL se_first_ok: err%b d%h s%b want 0 E1 1", sop_error, out_data, out_startofpacket); end
    cyc(); drive_port(1, 1'b1, 32'hE2, 1'b0, 1'b1); #1;
    n_checks++; if (sop_error !== 1'b1 || grant !== 4'b0010 || out_data !== 32'hE2) begin n_fail++; $display("FAIL se_pulse: err%b g%b d%h want 1 0010 E2", sop_error, grant, out_data); end
    cyc(); drive_port(1, 1'b0, 32'h0, 1'b0, 1'b0); #1;
    n_checks++; if (sop_error !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL se_end: err%b g%b want 0 0000", sop_error, grant); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive_port(3, 1'b1, 32'h30, 1'b1, 1'b0);
    cyc(); #1;
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rm_grant: g%b want 1000", grant); end
    cyc(); drive_port(3, 1'b1, 32'h31, 1'b0, 1'b0);
    cyc(); drive_port(3, 1'b1, 32'h32, 1'b0, 1'b0);
    drive_port(0, 1'b1, 32'h00, 1'b1, 1'b1);
    reset = 1'b1;
    cyc(); #1;
    n_checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_cleared: g%b v%b want 0000 0", grant, out_valid); end
    reset = 1'b0;
    cyc(); #1;
    n_checks++; if (grant !== 4'b0001 || out_data !== 32'h00) begin n_fail++; $display("FAIL rm_port0_wins: g%b d%h want 0001 00", grant, out_data); end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_stall();
    test_single_beat();
    test_sop_error();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
